// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder/accumulator.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR form the serial full adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/tt_um_serial_add_accum.sv
// TinyTapeout user-project wrapper around a 4-bit serial_add_accum.
module tt_um_serial_add_accum (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [3:0] sum;
    logic [3:0] acc_unused;
    logic       cout, busy, done;

    serial_add_accum #(.WIDTH(4)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (uio_in[0]),
        .mode    (uio_in[1]),
        .acc_clr (uio_in[2]),
        .a       (ui_in[3:0]),
        .b       (ui_in[7:4]),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .acc     (acc_unused)
    );

    assign uo_out  = {1'b0, done, busy, cout, sum};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_bits;
    assign unused_bits = &{1'b0, uio_in[7:3], acc_unused};

endmodule

// File: rtl/serial_add_accum.sv
// Bit-serial adder/accumulator: one result bit per enabled clock, LSB first.
module serial_add_accum
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] acc
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             mode_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;

    logic ha0_s, ha0_c, s_bit, ha1_c, carry_next;

    half_adder u_ha0 (.a(op_a[0]), .b(op_b[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.a(ha0_s),   .b(carry),   .s(s_bit), .c(ha1_c));

    assign carry_next = ha0_c | ha1_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            mode_q <= MODE_ADD;
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            acc    <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (acc_clr)
                        acc <= '0;
                    if (start) begin
                        op_a   <= a;
                        // A clear issued with the same start wins, so ACC+A sees zero.
                        op_b   <= (mode == MODE_ACC) ? (acc_clr ? '0 : acc) : b;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        mode_q <= mode;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    res   <= {s_bit, res[WIDTH-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= carry_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CNT_LAST)
                        state <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the result, the second retires to IDLE.
                    if (!done) begin
                        sum  <= res;
                        cout <= carry;
                        if (mode_q == MODE_ACC)
                            acc <= res;
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_accum.sv
// Directed bench for serial_add_accum (WIDTH=4) with hand-computed results.
module tb_serial_add_accum;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       mode;
    logic       acc_clr;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] acc;

    int compared;
    int mismatched;

    serial_add_accum #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .mode    (mode),
        .acc_clr (acc_clr),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .acc     (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full operation: start sampled at edge 0, done expected after edge 5 (+stall).
    task automatic do_op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                         input logic tm, input logic tclr, input bit noise, input int stall,
                         input bit hold_done, input logic [3:0] esum, input logic ecout,
                         input logic [3:0] eacc);
        int n;
        int pulses;
        a = ta; b = tb; mode = tm; acc_clr = tclr; start = 1'b1;
        tick();
        start = 1'b0; acc_clr = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        if (noise) begin
            start = 1'b1; acc_clr = 1'b1; a = 4'd1; b = 4'd1;
        end
        n = 0;
        while (!done && n < 30) begin
            if (stall > 0 && n == 2) begin
                ena = 1'b0;
                repeat (stall) begin
                    tick();
                    n++;
                end
                check({tag, "_busy_stall"}, 32'(busy), 32'd1);
                ena = 1'b1;
            end
            tick();
            n++;
        end
        start = 1'b0; acc_clr = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(5 + stall));
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_acc"}, 32'(acc), 32'(eacc));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        if (hold_done) begin
            ena = 1'b0;
            tick();
            check({tag, "_done_held"}, 32'(done), 32'd1);
            ena = 1'b1;
        end
        tick();
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        pulses = 0;
        repeat (3) begin
            tick();
            if (done) pulses++;
        end
        check({tag, "_extra_done"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        int pulses;
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 1'b0; acc_clr = 1'b0;
        a = '0; b = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);

        do_op("add_5_3",  4'd5,  4'd3, 1'b0, 1'b0, 0, 0, 0, 4'd8,  1'b0, 4'd0);
        do_op("add_15_1", 4'd15, 4'd1, 1'b0, 1'b0, 0, 0, 0, 4'd0,  1'b1, 4'd0);
        do_op("add_9_6",  4'd9,  4'd6, 1'b0, 1'b0, 0, 0, 0, 4'd15, 1'b0, 4'd0);

        // Accumulate chain: 0+7, 7+7, 14+7 wraps to 5 with carry out.
        do_op("acc_clr7", 4'd7, 4'd9, 1'b1, 1'b1, 0, 0, 0, 4'd7,  1'b0, 4'd7);
        do_op("acc_14",   4'd7, 4'd9, 1'b1, 1'b0, 0, 0, 0, 4'd14, 1'b0, 4'd14);
        do_op("acc_wrap", 4'd7, 4'd9, 1'b1, 1'b0, 0, 0, 0, 4'd5,  1'b1, 4'd5);

        do_op("busy_ign", 4'd2, 4'd2, 1'b0, 1'b0, 1, 0, 0, 4'd4, 1'b0, 4'd5);

        // Reset in the middle of a shift sequence.
        a = 4'd6; b = 4'd5; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_acc", 32'(acc), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        pulses = 0;
        repeat (8) begin
            tick();
            if (done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);

        do_op("add_3_4",  4'd3, 4'd4, 1'b0, 1'b0, 0, 0, 0, 4'd7,  1'b0, 4'd0);
        do_op("ena_stall", 4'd6, 4'd6, 1'b0, 1'b0, 0, 3, 1, 4'd12, 1'b0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
